// File: rtl/lsu_pkg.sv
// lsu_pkg: shared constants, state type and store-lane helper for the load/store unit
package lsu_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_t;
  typedef struct packed {
    logic [3:0]  strb;
    logic [31:0] data;
  } lanes_t;
  function automatic lanes_t store_lanes(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] d);
    lanes_t l;
    l.strb = f3 == F3_W ? 4'b1111 : f3 == F3_H ? 4'b0011 << {off[1], 1'b0} : 4'b0001 << off;
    l.data = f3 == F3_W ? d : f3 == F3_H ? {2{d[15:0]}} : {4{d[7:0]}};
    return l;
  endfunction
endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: selects the addressed byte/halfword of a read word and extends it
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);
  logic [7:0]  b;
  logic [15:0] h;
  assign b = rdata[{offset, 3'b000} +: 8];
  assign h = offset[1] ? rdata[31:16] : rdata[15:0];
  always_comb begin
    result = funct3 == F3_B  ? {{24{b[7]}}, b} :
             funct3 == F3_BU ? {24'b0, b} :
             funct3 == F3_H  ? {{16{h[15]}}, h} :
             funct3 == F3_HU ? {16'b0, h} : rdata;
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage unit issuing one valid/ready bus access per load/store
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       store_data,
  input  logic [4:0]        rd,
  output logic              lsu_stall,
  output logic              load_valid,
  output logic [31:0]       load_data,
  output logic [4:0]        load_rd,
  output logic              lsu_fault,
  output logic              bus_req_valid,
  input  logic              bus_req_ready,
  output logic              bus_req_write,
  output logic [ADDR_W-1:0] bus_req_addr,
  output logic [31:0]       bus_req_wdata,
  output logic [3:0]        bus_req_wstrb,
  input  logic              bus_rsp_valid,
  input  logic [31:0]       bus_rsp_rdata
);
  lsu_state_t  state;
  logic [1:0]  off;
  logic [2:0]  f3;
  logic [31:0] aligned;
  logic        access, legal, idle;
  lanes_t      lanes;

  assign access = mem_read | mem_write;
  assign legal = (funct3 == F3_B) | ((funct3 == F3_H) & !addr[0]) |
                 ((funct3 == F3_W) & (addr[1:0] == 2'b00)) |
                 (!mem_write & ((funct3 == F3_BU) | ((funct3 == F3_HU) & !addr[0])));
  assign idle = state == IDLE;
  assign lsu_stall = (idle & access & legal) | (state == REQ) | (state == WAIT);
  assign lsu_fault = idle & access & !legal;
  assign bus_req_valid = state == REQ;
  assign load_valid = (state == DONE) & !bus_req_write;
  assign lanes = store_lanes(funct3, addr[1:0], store_data);

  lsu_load_align u_align (
    .rdata (bus_rsp_rdata),
    .offset(off),
    .funct3(f3),
    .result(aligned)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      off <= '0;
      f3 <= '0;
      load_data <= '0;
      load_rd <= '0;
      bus_req_write <= 1'b0;
      bus_req_addr <= '0;
      bus_req_wdata <= '0;
      bus_req_wstrb <= '0;
    end else begin
      case (state)
        IDLE: if (access && legal) begin
          state <= REQ;
          off <= addr[1:0];
          f3 <= funct3;
          load_rd <= mem_read ? rd : load_rd;
          bus_req_write <= mem_write;
          bus_req_addr <= {addr[ADDR_W-1:2], 2'b00};
          bus_req_wdata <= mem_write ? lanes.data : '0;
          bus_req_wstrb <= mem_write ? lanes.strb : '0;
        end
        REQ: if (bus_req_ready) state <= WAIT;
        // responses are only meaningful here; anything seen in other states is dropped
        WAIT: if (bus_rsp_valid) begin
          state <= DONE;
          load_data <= bus_req_write ? load_data : aligned;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
